// File: rtl/regfile_sequencer.sv
// Maintenance master for the register file: fills every register with one value
// or streams every register out over valid/ready in index order.
module regfile_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_NUM_WIDTH = 5,
  parameter int REG_FILE_SIZE = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmdValid,
  output logic                     cmdReady,
  input  logic                     cmdOp,
  input  logic [DATA_WIDTH-1:0]    cmdData,
  output logic [REG_NUM_WIDTH-1:0] rfRdNum,
  input  logic [DATA_WIDTH-1:0]    rfRdData,
  output logic [REG_NUM_WIDTH-1:0] rfWrNum,
  output logic [DATA_WIDTH-1:0]    rfWrData,
  output logic                     rfWrEnable,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [DATA_WIDTH-1:0]    outData,
  output logic [REG_NUM_WIDTH-1:0] outNum,
  output logic                     outLast,
  output logic                     busy
);

  localparam logic [REG_NUM_WIDTH-1:0] LAST_IDX = REG_NUM_WIDTH'(REG_FILE_SIZE - 1);

  typedef enum logic [1:0] {IDLE, FILL, DUMP} state_t;

  state_t                   state;
  logic [REG_NUM_WIDTH-1:0] idx;
  logic [DATA_WIDTH-1:0]    fillVal;
  logic                     capDone;   // last index already captured into the buffer
  logic                     capture;
  logic                     beatTaken;

  assign capture    = (state == DUMP) && (!outValid || outReady) && !capDone;
  assign beatTaken  = outValid && outReady;

  assign cmdReady   = (state == IDLE);
  assign busy       = !cmdReady;
  assign rfWrEnable = (state == FILL);
  assign rfWrNum    = (state == FILL) ? idx : '0;
  assign rfWrData   = fillVal;
  assign rfRdNum    = (state == DUMP) ? idx : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= '0;
      fillVal  <= '0;
      capDone  <= 1'b0;
      outValid <= 1'b0;
      outData  <= '0;
      outNum   <= '0;
      outLast  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmdValid) begin
            fillVal <= cmdData;
            idx     <= '0;
            capDone <= 1'b0;
            state   <= cmdOp ? FILL : DUMP;
          end
        end
        FILL: begin
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DUMP: begin
          if (capture) begin
            outData  <= rfRdData;
            outNum   <= idx;
            outLast  <= (idx == LAST_IDX);
            outValid <= 1'b1;
            if (idx == LAST_IDX) capDone <= 1'b1;
            else                 idx     <= idx + 1'b1;
          end else if (beatTaken) begin
            outValid <= 1'b0;
          end
          // Last beat handed off: walk complete, release the interface.
          if (beatTaken && outLast) begin
            state    <= IDLE;
            outValid <= 1'b0;
            idx      <= '0;
            capDone  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Scoreboard bench for regfile_sequencer: a register-file model sits on the ports,
// expected dump beats and fill writes are queued, monitors pop and compare.
module tb_regfile_sequencer;

  logic        clk, rst;
  logic        cmdValid, cmdReady, cmdOp;
  logic [31:0] cmdData;
  logic [4:0]  rfRdNum, rfWrNum;
  logic [31:0] rfRdData, rfWrData;
  logic        rfWrEnable;
  logic        outValid, outReady, outLast, busy;
  logic [31:0] outData;
  logic [4:0]  outNum;

  regfile_sequencer dut (
    .clk(clk), .rst(rst),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp), .cmdData(cmdData),
    .rfRdNum(rfRdNum), .rfRdData(rfRdData),
    .rfWrNum(rfWrNum), .rfWrData(rfWrData), .rfWrEnable(rfWrEnable),
    .outValid(outValid), .outReady(outReady), .outData(outData),
    .outNum(outNum), .outLast(outLast), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: DUT write port plus a bench-side write port.
  logic [31:0] rf [32];
  logic        extWe;
  logic [4:0]  extNum;
  logic [31:0] extData;
  assign rfRdData = rf[rfRdNum];
  always @(posedge clk) begin
    if (rfWrEnable) rf[rfWrNum] <= rfWrData;
    if (extWe)      rf[extNum]  <= extData;
  end

  int passCnt = 0;
  int totalCnt = 0;
  int beatCnt = 0;

  typedef struct packed { logic [4:0] num; logic [31:0] data; logic last; } beat_t;
  typedef struct packed { logic [4:0] num; logic [31:0] data; } wr_t;
  beat_t expQ[$];
  wr_t   wrQ[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Dump-stream monitor plus stall-stability check.
  beat_t held;
  logic  heldVld = 1'b0;
  always @(negedge clk) begin
    if (!rst) heldVld = 1'b0;
    else begin
      if (heldVld && outValid)
        chk("stall_stable", {outNum, outData, outLast}, held);
      heldVld = 1'b0;
      if (outValid && outReady) begin
        beatCnt++;
        if (expQ.size() == 0) begin
          totalCnt++;
          $display("FAIL unexpected_beat: got num %0d with empty scoreboard", outNum);
        end else begin
          beat_t e;
          e = expQ.pop_front();
          chk("beat", {outNum, outData, outLast}, e);
        end
      end else if (outValid) begin
        held    = {outNum, outData, outLast};
        heldVld = 1'b1;
      end
    end
  end

  // Fill-write monitor.
  always @(negedge clk) begin
    if (rst && rfWrEnable) begin
      if (wrQ.size() == 0) begin
        totalCnt++;
        $display("FAIL unexpected_write: got num %0d with empty queue", rfWrNum);
      end else begin
        wr_t w;
        w = wrQ.pop_front();
        chk("fill_write", {rfWrNum, rfWrData}, w);
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [31:0] base, input logic [31:0] mul);
    for (int i = 0; i < 32; i++) begin
      extWe = 1'b1; extNum = 5'(i); extData = base | (32'(i) * mul);
      tick();
    end
    extWe = 1'b0;
  endtask

  task automatic issue(input logic op, input logic [31:0] d);
    cmdValid = 1'b1; cmdOp = op; cmdData = d;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (cmdReady) break;
    end
    tick();
    cmdValid = 1'b0;
  endtask

  // Called at the start of T+1; cycle numbers returned are relative to T.
  task automatic run(output int idleAt, output int wrCnt, output int firstWr, output int firstVal);
    int n;
    n = 1; idleAt = 0; wrCnt = 0; firstWr = 0; firstVal = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (rfWrEnable) begin wrCnt++; if (firstWr == 0) firstWr = n; end
      if (outValid && firstVal == 0) firstVal = n;
      if (cmdReady) begin idleAt = n; return; end
      tick();
      n++;
    end
    totalCnt++;
    $display("FAIL run_timeout: got busy after 400 cycles, expected idle");
  endtask

  int idleAt, wrCnt, firstWr, firstVal, b0;
  int stall;
  logic stalled;

  initial begin
    rst = 1'b0; cmdValid = 1'b0; cmdOp = 1'b0; cmdData = '0;
    outReady = 1'b1; extWe = 1'b0; extNum = '0; extData = '0;
    #3;
    chk("rst_outValid", outValid, 0);   chk("rst_outData", outData, 0);
    chk("rst_outNum", outNum, 0);       chk("rst_outLast", outLast, 0);
    chk("rst_rfWrEnable", rfWrEnable, 0); chk("rst_rfWrNum", rfWrNum, 0);
    chk("rst_rfWrData", rfWrData, 0);   chk("rst_rfRdNum", rfRdNum, 0);
    chk("rst_cmdReady", cmdReady, 1);   chk("rst_busy", busy, 0);
    @(negedge clk); rst = 1'b1;
    tick();

    // FILL then DUMP of the filled contents.
    for (int i = 0; i < 32; i++) wrQ.push_back({5'(i), 32'hDEADBEEF});
    issue(1'b1, 32'hDEADBEEF);
    run(idleAt, wrCnt, firstWr, firstVal);
    chk("fill_idle_cycle", idleAt, 33);
    chk("fill_wr_count", wrCnt, 32);
    chk("fill_first_wr", firstWr, 1);
    tick();
    for (int i = 0; i < 32; i++) expQ.push_back({5'(i), 32'hDEADBEEF, i == 31});
    issue(1'b0, 32'h0);
    run(idleAt, wrCnt, firstWr, firstVal);
    chk("dump1_idle_cycle", idleAt, 34);

    // Preloaded i*0x11, full-rate dump.
    tick();
    preload(32'h0, 32'h11);
    for (int i = 0; i < 32; i++) expQ.push_back({5'(i), 32'(i) * 32'h11, i == 31});
    issue(1'b0, 32'h0);
    run(idleAt, wrCnt, firstWr, firstVal);
    chk("dump2_first_valid", firstVal, 2);
    chk("dump2_idle_cycle", idleAt, 34);
    chk("dump2_no_writes", wrCnt, 0);

    // Toggling outReady with a 5-cycle stall at index 7.
    tick();
    preload(32'hA0000000, 32'h1);
    for (int i = 0; i < 32; i++) expQ.push_back({5'(i), 32'hA0000000 | 32'(i), i == 31});
    b0 = beatCnt; stall = 0; stalled = 1'b0;
    issue(1'b0, 32'h0);
    for (int k = 0; k < 400; k++) begin
      if (stall > 0) begin outReady = 1'b0; stall--; end
      else if (!stalled && outValid && outNum == 5'd7) begin
        outReady = 1'b0; stall = 4; stalled = 1'b1;
      end else outReady = !outReady;
      @(negedge clk);
      if (cmdReady) break;
      tick();
    end
    outReady = 1'b1;
    chk("toggle_beat_count", beatCnt - b0, 32);
    chk("toggle_stall_seen", stalled, 1);

    // FILL request held during a DUMP waits for IDLE.
    tick();
    for (int i = 0; i < 32; i++) expQ.push_back({5'(i), 32'hA0000000 | 32'(i), i == 31});
    for (int i = 0; i < 32; i++) wrQ.push_back({5'(i), 32'h12345678});
    issue(1'b0, 32'h0);
    cmdValid = 1'b1; cmdOp = 1'b1; cmdData = 32'h12345678;
    run(idleAt, wrCnt, firstWr, firstVal);
    chk("hold_dump_idle_cycle", idleAt, 34);
    chk("hold_no_early_fill", wrCnt, 0);
    tick();
    cmdValid = 1'b0;
    run(idleAt, wrCnt, firstWr, firstVal);
    chk("hold_fill_first_wr", firstWr, 1);
    chk("hold_fill_idle", idleAt, 33);

    // External write to reg 20 during a dump is visible.
    tick();
    for (int i = 0; i < 32; i++)
      expQ.push_back({5'(i), (i == 20) ? 32'h00005A5A : 32'h12345678, i == 31});
    issue(1'b0, 32'h0);
    repeat (4) tick();
    extWe = 1'b1; extNum = 5'd20; extData = 32'h00005A5A;
    tick();
    extWe = 1'b0;
    run(idleAt, wrCnt, firstWr, firstVal);

    // Asynchronous reset in the middle of a dump.
    tick();
    for (int i = 0; i < 32; i++)
      expQ.push_back({5'(i), (i == 20) ? 32'h00005A5A : 32'h12345678, i == 31});
    issue(1'b0, 32'h0);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (outValid && outNum == 5'd5) break;
    end
    chk("abort_at_beat5", outNum, 5);
    #2 rst = 1'b0;
    #1;
    chk("abort_outValid", outValid, 0);
    chk("abort_rfWrEnable", rfWrEnable, 0);
    chk("abort_busy", busy, 0);
    expQ.delete();
    #1 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_cmdReady", cmdReady, 1);
    chk("post_rst_outValid", outValid, 0);

    chk("scoreboard_empty", expQ.size(), 0);
    chk("write_queue_empty", wrQ.size(), 0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
